// File: rtl/face_detect_haar_acc_pkg.sv
// Shared types and widths for the Haar feature accumulator.
package face_detect_haar_acc_pkg;

    localparam int PROD_W = 32;
    localparam int LEAF_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    // Side-band information travelling alongside each multiplier operand pair.
    typedef struct packed {
        logic                     valid;
        logic                     last;
        logic signed [PROD_W-1:0] thresh;
        logic signed [LEAF_W-1:0] left;
        logic signed [LEAF_W-1:0] right;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/face_detect_haar_tag_dly.sv
// Delays the issue tag so that it lines up with the multiplier product.
import face_detect_haar_acc_pkg::*;

module face_detect_haar_tag_dly #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_pipe [0:DEPTH-1];

    // Shift the tag one stage per enabled cycle; hold everything when stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= tag_t'({TAG_W{1'b0}});
            end
        end else if (ce) begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/face_detect_haar_acc.sv
// Accumulates weighted rectangle products of one Haar feature and compares
// the sum against the feature threshold to pick a leaf value.
import face_detect_haar_acc_pkg::*;

module face_detect_haar_acc #(
    parameter int MUL_LATENCY = 3,
    parameter int MAX_RECTS   = 3,
    parameter int ACC_WIDTH   = 34
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        issue_valid,
    input  logic                        issue_last,
    input  logic signed [PROD_W-1:0]    issue_thresh,
    input  logic signed [LEAF_W-1:0]    issue_left,
    input  logic signed [LEAF_W-1:0]    issue_right,
    input  logic signed [PROD_W-1:0]    prod,
    output logic                        out_valid,
    output logic signed [ACC_WIDTH-1:0] out_sum,
    output logic                        out_pass,
    output logic signed [LEAF_W-1:0]    out_val,
    output logic                        out_err
);

    localparam int CNT_W = $clog2(MAX_RECTS + 1);
    localparam int EXT_W = ACC_WIDTH - PROD_W;

    tag_t                        w_tag_in;
    tag_t                        w_tag;
    state_e                      r_state;
    state_e                      w_state_nxt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_acc_nxt;
    logic        [CNT_W-1:0]     r_cnt;
    logic        [CNT_W-1:0]     w_cnt_nxt;
    logic        [CNT_W-1:0]     w_cnt_inc;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_thr_ext;
    logic signed [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic                        w_emit;
    logic                        w_err;
    logic                        w_pass;

    assign w_tag_in.valid  = issue_valid;
    assign w_tag_in.last   = issue_last;
    assign w_tag_in.thresh = issue_thresh;
    assign w_tag_in.left   = issue_left;
    assign w_tag_in.right  = issue_right;

    face_detect_haar_tag_dly #(
        .DEPTH (MUL_LATENCY)
    ) u_tag_dly (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .i_tag (w_tag_in),
        .o_tag (w_tag)
    );

    // Datapath: sum, rectangle count, emit/truncate decision and next state.
    always_comb begin
        w_prod_ext  = {{EXT_W{prod[PROD_W-1]}}, prod};
        w_thr_ext   = {{EXT_W{w_tag.thresh[PROD_W-1]}}, w_tag.thresh};
        w_base      = {ACC_WIDTH{1'b0}};
        w_cnt_inc   = CNT_W'(1);
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_emit      = 1'b0;
        w_err       = 1'b0;

        // In IDLE the incoming product is the first of a feature.
        if (r_state == ST_ACC) begin
            w_base    = r_acc;
            w_cnt_inc = r_cnt + CNT_W'(1);
        end else begin
            w_base    = {ACC_WIDTH{1'b0}};
            w_cnt_inc = CNT_W'(1);
        end

        w_sum  = w_base + w_prod_ext;
        w_pass = (w_sum >= w_thr_ext);

        if (w_tag.valid) begin
            w_emit = w_tag.last || (w_cnt_inc == CNT_W'(MAX_RECTS));
            w_err  = w_emit && !w_tag.last;
        end else begin
            w_emit = 1'b0;
            w_err  = 1'b0;
        end

        case (r_state)
            ST_IDLE, ST_ACC: begin
                if (w_tag.valid && w_emit) begin
                    w_state_nxt = ST_IDLE;
                    w_acc_nxt   = {ACC_WIDTH{1'b0}};
                    w_cnt_nxt   = CNT_W'(0);
                end else if (w_tag.valid) begin
                    w_state_nxt = ST_ACC;
                    w_acc_nxt   = w_sum;
                    w_cnt_nxt   = w_cnt_inc;
                end else begin
                    w_state_nxt = r_state;
                    w_acc_nxt   = r_acc;
                    w_cnt_nxt   = r_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_acc_nxt   = {ACC_WIDTH{1'b0}};
                w_cnt_nxt   = CNT_W'(0);
            end
        endcase
    end

    // FSM state, running sum and rectangle count advance only when enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_acc   <= {ACC_WIDTH{1'b0}};
            r_cnt   <= CNT_W'(0);
        end else if (ce) begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Result registers capture on emit and hold until the next feature completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_sum  <= {ACC_WIDTH{1'b0}};
            out_pass <= 1'b0;
            out_val  <= {LEAF_W{1'b0}};
            out_err  <= 1'b0;
        end else if (ce && w_emit) begin
            out_sum  <= w_sum;
            out_pass <= w_pass;
            out_val  <= w_pass ? w_tag.right : w_tag.left;
            out_err  <= w_err;
        end
    end

    // The valid pulse is rewritten every edge so it never sticks high during a stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= ce & w_emit;
        end
    end

endmodule

// File: tb/tb_face_detect_haar_acc.sv
// Scoreboard bench for face_detect_haar_acc with a ce-gated multiplier model.
module tb_face_detect_haar_acc;

    localparam int LAT = 3;
    localparam int AW  = 34;

    typedef struct {
        longint sum;
        int     pass;
        int     val;
        int     err;
        int     cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               ce = 1'b1;
    logic               issue_valid = 1'b0;
    logic               issue_last = 1'b0;
    logic signed [31:0] issue_thresh = 32'sd0;
    logic signed [15:0] issue_left = 16'sd0;
    logic signed [15:0] issue_right = 16'sd0;
    logic signed [31:0] stim_prod = 32'sd0;
    logic signed [31:0] prod;
    logic               out_valid;
    logic signed [AW-1:0] out_sum;
    logic               out_pass;
    logic signed [15:0] out_val;
    logic               out_err;

    logic signed [31:0] mul_pipe [0:LAT-1];
    exp_t               sb [$];
    int                 checks = 0;
    int                 failures = 0;
    int                 n_out = 0;
    int                 cyc = 0;
    int                 n_before;

    face_detect_haar_acc #(
        .MUL_LATENCY (LAT),
        .MAX_RECTS   (3),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .issue_valid  (issue_valid),
        .issue_last   (issue_last),
        .issue_thresh (issue_thresh),
        .issue_left   (issue_left),
        .issue_right  (issue_right),
        .prod         (prod),
        .out_valid    (out_valid),
        .out_sum      (out_sum),
        .out_pass     (out_pass),
        .out_val      (out_val),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream multiplier model: product appears LAT enabled edges after issue.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) mul_pipe[i] <= 32'sd0;
        end else if (ce) begin
            mul_pipe[0] <= stim_prod;
            for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end
    assign prod = mul_pipe[LAT-1];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected result for the feature whose final product is issued next.
    task automatic push_exp(input longint s, input int p, input int v, input int e, input bit lat);
        exp_t x;
        x.sum = s; x.pass = p; x.val = v; x.err = e;
        x.cyc = lat ? (cyc + LAT + 1) : -1;
        sb.push_back(x);
    endtask

    task automatic do_issue(input int p, input bit last, input int thr, input int l, input int r);
        issue_valid  = 1'b1;
        issue_last   = last;
        stim_prod    = 32'(p);
        issue_thresh = 32'(thr);
        issue_left   = 16'(l);
        issue_right  = 16'(r);
        @(posedge clk); #1;
        issue_valid  = 1'b0;
        issue_last   = 1'b0;
        stim_prod    = 32'sd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every out_valid pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            exp_t e;
            n_out++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=1 expected=0 sum=%0d (t=%0t)", out_sum, $time);
            end else begin
                e = sb.pop_front();
                check("out_sum", longint'(out_sum), e.sum);
                check("out_pass", longint'(out_pass), longint'(e.pass));
                check("out_val", longint'(out_val), longint'(e.val));
                check("out_err", longint'(out_err), longint'(e.err));
                if (e.cyc >= 0) check("latency_cycle", longint'(cyc), longint'(e.cyc));
            end
        end
    end

    initial begin
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_sum", longint'(out_sum), 0);
        check("rst_out_val", longint'(out_val), 0);
        idle(2);
        reset = 1'b1;
        idle(1);

        // Three rects 100,-40,5 thr 65 then a back-to-back single rect -1 thr 0.
        do_issue(100, 1'b0, 65, -3, 7);
        do_issue(-40, 1'b0, 65, -3, 7);
        push_exp(65, 1, 7, 0, 1'b1);
        do_issue(5, 1'b1, 65, -3, 7);
        push_exp(-1, 0, -9, 0, 1'b1);
        do_issue(-1, 1'b1, 0, -9, 9);
        idle(8);

        // Truncation: four issues without last, then a last closes the second feature.
        do_issue(10, 1'b0, 100, -5, 5);
        do_issue(20, 1'b0, 100, -5, 5);
        push_exp(60, 0, -5, 1, 1'b1);
        do_issue(30, 1'b0, 100, -5, 5);
        do_issue(40, 1'b0, 41, -6, 6);
        push_exp(41, 1, 6, 0, 1'b1);
        do_issue(1, 1'b1, 41, -6, 6);
        idle(8);

        // Stall mid-feature: 7+8-20 = -5 equals the threshold, so it passes.
        do_issue(7, 1'b0, -5, -2, 2);
        do_issue(8, 1'b0, -5, -2, 2);
        push_exp(-5, 1, 2, 0, 1'b0);
        do_issue(-20, 1'b1, -5, -2, 2);
        ce = 1'b0;
        n_before = n_out;
        idle(5);
        check("stall_no_out_valid", longint'(n_out), longint'(n_before));
        ce = 1'b1;
        idle(8);

        // Reset while accumulating: outputs clear and the aborted feature never emits.
        do_issue(11, 1'b0, 0, -1, 1);
        do_issue(22, 1'b0, 0, -1, 1);
        idle(4);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_out_sum", longint'(out_sum), 0);
        check("midrst_out_pass", longint'(out_pass), 0);
        check("midrst_out_val", longint'(out_val), 0);
        check("midrst_out_err", longint'(out_err), 0);
        @(posedge clk); #1;
        n_before = n_out;
        do_issue(99, 1'b1, 0, -1, 1);
        idle(1);
        reset = 1'b1;
        idle(8);
        check("midrst_no_emit", longint'(n_out), longint'(n_before));

        // Full-scale single-rect features on every cycle.
        push_exp(64'sd2147483647, 1, 100, 0, 1'b1);
        do_issue(32'sh7FFFFFFF, 1'b1, 0, -100, 100);
        push_exp(-64'sd2147483648, 0, -100, 0, 1'b1);
        do_issue(32'sh80000000, 1'b1, 0, -100, 100);
        push_exp(64'sd2147483647, 1, 100, 0, 1'b1);
        do_issue(32'sh7FFFFFFF, 1'b1, 0, -100, 100);
        push_exp(-64'sd2147483648, 0, -100, 0, 1'b1);
        do_issue(32'sh80000000, 1'b1, 0, -100, 100);
        idle(10);

        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/face_detect_haar_acc.md
FACE_DETECT_HAAR_ACC -- requirements
Module: face_detect_haar_acc

Interface
REQ-001 Parameter MUL_LATENCY, default 3: edges from operand issue at the multiplier to product valid on prod.
REQ-002 Parameter MAX_RECTS, default 3: maximum weighted rectangles per Haar feature.
REQ-003 Parameter ACC_WIDTH, default 34: signed accumulator width.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port ce, input, 1: pipeline enable, the same signal that drives the upstream multiplier's ce.
REQ-007 Port issue_valid, input, 1: rectangle operands are presented to the multiplier this cycle.
REQ-008 Port issue_last, input, 1: the issued rectangle is the feature's last; qualified by issue_valid.
REQ-009 Port issue_thresh, input, 32, signed: feature threshold; sampled only with issue_valid&issue_last.
REQ-010 Port issue_left, input, 16, signed: leaf value on fail; sampled with issue_last.
REQ-011 Port issue_right, input, 16, signed: leaf value on pass; sampled with issue_last.
REQ-012 Port prod, input, 32, signed: multiplier dout.
REQ-013 Port out_valid, output, 1: one-cycle pulse marking a completed feature.
REQ-014 Port out_sum, output, ACC_WIDTH, signed: final weighted sum.
REQ-015 Port out_pass, output, 1: out_sum >= threshold.
REQ-016 Port out_val, output, 16, signed: issue_right if pass, else issue_left.
REQ-017 Port out_err, output, 1: the feature was truncated at MAX_RECTS; valid with out_valid.

Function
REQ-018 Tag pipeline: {valid, last, thresh, left, right} delayed MUL_LATENCY stages, advancing only when ce=1, so the tag aligns with prod.
REQ-019 Every state element except out_valid holds its value when ce=0.
REQ-020 State IDLE, aligned valid tag, not last: acc <= sext(prod), cnt <= 1, go to ACC.
REQ-021 State IDLE, aligned valid tag with last: emit sext(prod); stay IDLE.
REQ-022 State ACC, aligned valid tag: sum = acc + sext(prod), cnt <= cnt+1.
REQ-023 In ACC, if last=1, or cnt+1 = MAX_RECTS: emit sum and return to IDLE.
REQ-024 Truncation: if cnt+1 = MAX_RECTS with last=0, out_err=1 on that emit; the next product starts a new feature.
REQ-025 Emit registers out_sum, out_pass, out_val and out_err on the same edge as the final product, so outputs appear 1 cycle after the final product is on prod.
REQ-026 Comparison: signed, with thresh sign-extended to ACC_WIDTH; equality counts as pass.
REQ-027 out_valid register <= ce & emit on every edge, independent of ce gating, so it pulses exactly once per feature.
REQ-028 out_sum, out_pass, out_val and out_err hold their values until the next emit.
REQ-029 Back-to-back features (a last product followed by a first product the next cycle) are accepted with no bubble.
REQ-030 The accumulation never overflows: the ACC_WIDTH default covers MAX_RECTS products.

Reset
REQ-031 Asserting reset clears the tag pipeline, state to IDLE, and acc, cnt and all outputs to 0, mid-feature included.
REQ-032 Products issued before reset deassertion are never emitted.

Structure
REQ-033 A shared package holds the state enum (IDLE, ACC) and the width constants: 32 for product, 16 for leaf value.
REQ-034 One sub-module, face_detect_haar_tag_dly, implements the MUL_LATENCY-deep ce-gated tag shift register.

Verification
REQ-035 Three rects with products 100, -40, 5 and thresh 65 -> one out_valid; out_sum=65, out_pass=1, out_val=right.
REQ-036 Single-rect feature with prod -1 and thresh 0 -> out_sum=-1, out_pass=0, out_val=left, 1 cycle after prod.
REQ-037 Four issues with no last (MAX_RECTS=3) -> first emit has out_err=1 and sums 3 products; the 4th product starts a new feature.
REQ-038 ce held 0 for 5 cycles mid-feature -> no out_valid during the stall; the sum after resume is unchanged.
REQ-039 Reset asserted while in ACC after 2 products -> all outputs 0; no emit for the aborted feature.
REQ-040 Alternating 1-rect features every cycle with products 2^31-1 and -2^31 -> out_valid on every cycle with exact sign-extended sums.
